// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, request-to-send, shift, ACK check).
// Optional request-to-ACK timeout enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       ready,
  output logic       done,
  output logic       ack_err
);
  localparam int CW = $clog2(INHIBIT_CYCLES + TIMEOUT_CYCLES + 1);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INHIBIT   = 3'd1;
  localparam logic [2:0] REQ       = 3'd2;
  localparam logic [2:0] SHIFT     = 3'd3;
  localparam logic [2:0] ACK       = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [9:0]    sr;
  logic [3:0]    idx;
  logic          err_pend;
  logic          clk_s1, clk_s2, clk_d, dat_s1, dat_s2;
  logic          fall;
  assign fall = clk_d & ~clk_s2;
  // sr holds {stop, parity, data}; shifting in ones makes the stop bit fall out naturally
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '1;
      idx        <= '0;
      err_pend   <= 1'b0;
      {clk_s1, clk_s2, clk_d} <= 3'b111;
      {dat_s1, dat_s2}        <= 2'b11;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      ready      <= 1'b1;
      done       <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      {clk_s1, clk_s2, clk_d} <= {ps2_clk_in, clk_s1, clk_s2};
      {dat_s1, dat_s2}        <= {ps2_dat_in, dat_s1};
      done    <= 1'b0;
      ack_err <= 1'b0;
      case (state)
        IDLE: if (send) begin
          sr         <= {1'b1, ~^tx_data, tx_data};
          cnt        <= '0;
          ready      <= 1'b0;
          ps2_clk_oe <= 1'b1;
          state      <= INHIBIT;
        end
        INHIBIT: if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          ps2_dat_oe <= 1'b1;
          cnt        <= '0;
          state      <= REQ;
        end else cnt <= cnt + 1'b1;
        REQ: begin
          ps2_clk_oe <= 1'b0;
          idx        <= '0;
          state      <= SHIFT;
        end
        SHIFT: if (fall) begin
          ps2_dat_oe <= ~sr[0];
          sr         <= {1'b1, sr[9:1]};
          idx        <= idx + 4'd1;
          if (idx == 4'd9) state <= ACK;
        end
        ACK: if (fall) begin
          err_pend <= dat_s2;
          state    <= WAIT_IDLE;
        end
        WAIT_IDLE: if (clk_s2 && dat_s2) begin
          done    <= 1'b1;
          ack_err <= err_pend;
          state   <= DONE;
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          ready      <= 1'b1;
          state      <= IDLE;
        end
      endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
      if (state inside {REQ, SHIFT, ACK, WAIT_IDLE}) begin
        if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          done       <= 1'b1;
          ack_err    <= 1'b1;
          state      <= DONE;
        end else cnt <= cnt + 1'b1;
      end
`endif
    end
  end
endmodule
